// File: rtl/multi_dataflow_mul_mdc_package.sv
// Shared types and constants for the mul_mdc output collector stage.
package multi_dataflow_mul_mdc_package;

    localparam int unsigned MULTI_DATAFLOW_MUL_MDC_OUT_FIFO_DEPTH = 4;
    localparam int unsigned MULTI_DATAFLOW_MUL_MDC_CNT_WIDTH      = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } out_collector_state_t;

    typedef struct packed {
        logic                                        clear;
        logic                                        start;
        logic [MULTI_DATAFLOW_MUL_MDC_CNT_WIDTH-1:0] len;
    } ctrl_out_collector_t;

    typedef struct packed {
        logic                                        busy;
        logic                                        done;
        logic [MULTI_DATAFLOW_MUL_MDC_CNT_WIDTH-1:0] cnt;
        logic                                        overflow;
    } flags_out_collector_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle: a beat transfers on a rising edge where valid && ready;
// the source holds valid, data and strb stable until that beat is accepted.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/multi_dataflow_mul_mdc_out_fifo.sv
// Small register FIFO; pointers carry one extra wrap bit so full and empty are distinct.
module multi_dataflow_mul_mdc_out_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: an entry is only observed after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/multi_dataflow_mul_mdc_out_collector.sv
// Buffers the kernel output stream toward the streamer, counts a job's outputs
// against its programmed length, pulses done at job end and flags surplus tokens.
module multi_dataflow_mul_mdc_out_collector
    import multi_dataflow_mul_mdc_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = MULTI_DATAFLOW_MUL_MDC_OUT_FIFO_DEPTH,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    hwpe_stream_intf_stream.sink   in_i,
    hwpe_stream_intf_stream.source out_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 overflow_o
);

    out_collector_state_t state_q, state_d;

    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  cnt_in_q;
    logic [CNT_WIDTH-1:0]  cnt_o_q;
    logic                  overflow_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  in_ready;
    logic                  push;
    logic                  pop;
    logic                  last_push;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  unused_strb;

    assign in_ready  = (state_q == RUN) && !fifo_full && (cnt_in_q < len_q);
    assign push      = in_i.valid && in_ready;
    assign pop       = !fifo_empty && out_o.ready;
    // Compared against len-1 so a maximal length never needs a wider sum.
    assign last_push = push && (cnt_in_q == len_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1});

    assign in_i.ready  = in_ready;
    assign out_o.valid = !fifo_empty;
    assign out_o.data  = fifo_head;
    assign out_o.strb  = '1;
    assign unused_strb = ^in_i.strb;

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign cnt_o      = cnt_o_q;
    assign overflow_o = overflow_q;

    multi_dataflow_mul_mdc_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_i.data),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (len_i != '0) ? RUN : DONE;
            RUN:     if (last_push) state_d = DRAIN;
            DRAIN:   if (fifo_empty && !pop) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q      <= '0;
            cnt_in_q   <= '0;
            cnt_o_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            len_q      <= '0;
            cnt_in_q   <= '0;
            cnt_o_q    <= '0;
            overflow_q <= 1'b0;
        end else if (state_q == IDLE && start_i) begin
            len_q      <= len_i;
            cnt_in_q   <= '0;
            cnt_o_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) cnt_in_q <= cnt_in_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (pop)  cnt_o_q  <= cnt_o_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (state_q == DRAIN && in_i.valid) overflow_q <= 1'b1;
        end
    end

endmodule
